// File: rtl/fir_pkg.sv
// Shared widths and saturation limits for the FIR requantize/decimate datapath.
package fir_pkg;
    localparam int IN_W    = 16;
    localparam int OUT_W   = 8;
    localparam int SAT_MAX = 127;
    localparam int SAT_MIN = -128;
endpackage

// File: rtl/fir_requant_decim_if.sv
// Sample stream in, decimated stream out (valid/ready on the output side only).
interface fir_requant_decim_if;
    import fir_pkg::*;
    logic signed [IN_W-1:0]  data_in;
    logic                    in_valid;
    logic signed [OUT_W-1:0] out_data;
    logic                    out_valid;
    logic                    out_ready;

    modport master (output data_in, in_valid, out_ready, input out_data, out_valid);
    modport slave  (input data_in, in_valid, out_ready, output out_data, out_valid);
endinterface

// File: rtl/fir_requant_decim_sync_fifo.sv
// Synchronous FIFO; extra pointer MSB separates full from empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wp, rp;
    logic             do_push, do_pop;

    assign empty   = (wp == rp);
    assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop frees the head slot on the same edge, so a full FIFO still accepts.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rp[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (do_push) wp <= wp + (AW+1)'(1);
            if (do_pop)  rp <= rp + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wp[AW-1:0]] <= din;
    end
endmodule

// File: rtl/fir_requant_decim.sv
// Integrate-and-dump decimator with round-half-up requantization, saturation and output FIFO.
module fir_requant_decim
    import fir_pkg::*;
#(
    parameter int DEC_FACTOR = 4,
    parameter int SHIFT      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    fir_requant_decim_if.slave  bus,
    output logic                sat_flag,
    output logic                ovf_flag
);
    localparam int ACC_W = IN_W + $clog2(DEC_FACTOR);
    localparam int CNT_W = $clog2(DEC_FACTOR);
    localparam int HALF  = 1 << (SHIFT - 1);
    localparam logic signed [ACC_W:0] HI = (ACC_W+1)'(SAT_MAX);
    localparam logic signed [ACC_W:0] LO = (ACC_W+1)'(SAT_MIN);

    logic signed [ACC_W-1:0] acc, sum;
    logic        [CNT_W-1:0] cnt;
    logic signed [ACC_W:0]   rnd, r;
    logic signed [OUT_W-1:0] q, stage_data, fifo_dout;
    logic                    dump, clip_hi, clip_lo, stage_valid;
    logic                    full, empty, pop, sat_set, ovf_set;

    assign dump = bus.in_valid && (cnt == CNT_W'(DEC_FACTOR - 1));
    assign sum  = acc + $signed({{(ACC_W-IN_W){bus.data_in[IN_W-1]}}, bus.data_in});

    // One guard bit so the rounding offset cannot wrap a maximal sum.
    assign rnd     = $signed({sum[ACC_W-1], sum}) + (ACC_W+1)'(HALF);
    assign r       = rnd >>> SHIFT;
    assign clip_hi = (r > HI);
    assign clip_lo = (r < LO);
    assign q       = clip_hi ? OUT_W'(SAT_MAX) : clip_lo ? OUT_W'(SAT_MIN) : r[OUT_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc         <= '0;
            cnt         <= '0;
            stage_valid <= 1'b0;
            stage_data  <= '0;
        end else begin
            stage_valid <= dump;
            if (bus.in_valid) begin
                if (dump) begin
                    acc        <= '0;
                    cnt        <= '0;
                    stage_data <= q;
                end else begin
                    acc <= sum;
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

    assign pop     = !empty && bus.out_ready;
    assign sat_set = dump && (clip_hi || clip_lo);
    assign ovf_set = stage_valid && full && !pop;

    // Set beats a coincident clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_flag <= 1'b0;
            ovf_flag <= 1'b0;
        end else begin
            sat_flag <= sat_set || (sat_flag && !clr);
            ovf_flag <= ovf_set || (ovf_flag && !clr);
        end
    end

    sync_fifo #(.WIDTH(OUT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (stage_valid),
        .pop   (pop),
        .din   (stage_data),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty)
    );

    assign bus.out_valid = !empty;
    assign bus.out_data  = empty ? '0 : fifo_dout;
endmodule

// File: tb/tb_fir_requant_decim.sv
// Directed scenarios plus random traffic against a queue-level reference model.
module tb_fir_requant_decim;
    localparam int DEC = 4;
    localparam int SH  = 4;
    localparam int FD  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr = 1'b0;
    logic sat_flag, ovf_flag;

    fir_requant_decim_if bus();

    fir_requant_decim #(.DEC_FACTOR(DEC), .SHIFT(SH), .FIFO_DEPTH(FD)) dut (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .bus      (bus),
        .sat_flag (sat_flag),
        .ovf_flag (ovf_flag)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    // reference model state
    int grp[$];
    int q_m[$];
    bit stg_v;
    int stg_d;
    bit sat_m, ovf_m;

    task automatic chk(input string tag, input int got, input int exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int fdiv(input int a, input int b);
        return (a >= 0) ? a / b : -((-a + b - 1) / b);
    endfunction

    task automatic model_clear();
        grp.delete();
        q_m.delete();
        stg_v = 0;
        stg_d = 0;
        sat_m = 0;
        ovf_m = 0;
    endtask

    task automatic step(input int d, input bit v, input bit r, input bit c);
        bit full_m, pop_m, sat_set, ovf_set;
        int sum, rq;
        @(negedge clk);
        bus.data_in  = 16'(d);
        bus.in_valid = v;
        bus.out_ready = r;
        clr = c;
        full_m  = (q_m.size() == FD);
        pop_m   = (q_m.size() > 0) && r;
        sat_set = 0;
        ovf_set = 0;
        if (pop_m) void'(q_m.pop_front());
        if (stg_v) begin
            if (!full_m || pop_m) q_m.push_back(stg_d);
            else ovf_set = 1;
        end
        stg_v = 0;
        if (v) begin
            grp.push_back(d);
            if (grp.size() == DEC) begin
                sum = 0;
                foreach (grp[i]) sum += grp[i];
                rq = fdiv(sum + (1 << (SH - 1)), 1 << SH);
                if (rq > 127)       begin rq = 127;  sat_set = 1; end
                else if (rq < -128) begin rq = -128; sat_set = 1; end
                stg_v = 1;
                stg_d = rq;
                grp.delete();
            end
        end
        sat_m = sat_set || (sat_m && !c);
        ovf_m = ovf_set || (ovf_m && !c);
        @(posedge clk);
        #1;
        chk("out_valid", int'(bus.out_valid), (q_m.size() > 0) ? 1 : 0);
        chk("out_data", int'(bus.out_data), (q_m.size() > 0) ? q_m[0] : 0);
        chk("sat_flag", int'(sat_flag), int'(sat_m));
        chk("ovf_flag", int'(ovf_flag), int'(ovf_m));
    endtask

    task automatic idle(input bit r);
        step(0, 1'b0, r, 1'b0);
    endtask

    task automatic group4(input int d, input bit r);
        for (int i = 0; i < DEC; i++) step(d, 1'b1, r, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_out_data", int'(bus.out_data), 0);
        chk("rst_sat", int'(sat_flag), 0);
        chk("rst_ovf", int'(ovf_flag), 0);
        model_clear();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [15:0] rnd16;
        int d;
        bus.data_in = '0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk("init_out_valid", int'(bus.out_valid), 0);
        chk("init_out_data", int'(bus.out_data), 0);
        @(negedge clk);
        rst = 1'b0;

        // basic group: 4 x 100 -> 25, two edges of latency
        group4(100, 1'b1);
        chk("lat_not_yet", int'(bus.out_valid), 0);
        idle(1'b1);
        chk("lat_valid", int'(bus.out_valid), 1);
        chk("basic_25", int'(bus.out_data), 25);
        chk("basic_nosat", int'(sat_flag), 0);
        idle(1'b1);
        chk("basic_drained", int'(bus.out_valid), 0);

        // saturation both ways, then clear
        group4(1000, 1'b1);
        idle(1'b0);
        chk("sat_pos", int'(bus.out_data), 127);
        chk("sat_pos_flag", int'(sat_flag), 1);
        idle(1'b1);
        group4(-1000, 1'b1);
        idle(1'b0);
        chk("sat_neg", int'(bus.out_data), -128);
        idle(1'b1);
        step(0, 1'b0, 1'b1, 1'b1);
        chk("sat_clr", int'(sat_flag), 0);

        // rounding
        group4(6, 1'b1);   idle(1'b0); chk("rnd_p24", int'(bus.out_data), 2);  idle(1'b1);
        group4(-6, 1'b1);  idle(1'b0); chk("rnd_m24", int'(bus.out_data), -1); idle(1'b1);
        group4(2, 1'b1);   idle(1'b0); chk("rnd_8", int'(bus.out_data), 1);    idle(1'b1);
        step(1, 1'b1, 1'b1, 1'b0);
        step(2, 1'b1, 1'b1, 1'b0);
        step(2, 1'b1, 1'b1, 1'b0);
        step(2, 1'b1, 1'b1, 1'b0);
        idle(1'b0);
        chk("rnd_7_valid", int'(bus.out_valid), 1);
        chk("rnd_7", int'(bus.out_data), 0);
        idle(1'b1);

        // overflow: 5 groups into a 4-deep FIFO with no consumer
        for (int g = 0; g < 5; g++) group4(16, 1'b0);
        idle(1'b0);
        idle(1'b0);
        chk("ovf_set", int'(ovf_flag), 1);
        for (int k = 0; k < FD; k++) begin
            chk("ovf_drain_valid", int'(bus.out_valid), 1);
            chk("ovf_drain_data", int'(bus.out_data), 4);
            idle(1'b1);
        end
        chk("ovf_drained", int'(bus.out_valid), 0);
        step(0, 1'b0, 1'b1, 1'b1);
        chk("ovf_clr", int'(ovf_flag), 0);

        // full FIFO with simultaneous pop: no overflow
        for (int g = 0; g < 4; g++) group4(16, 1'b0);
        idle(1'b0);
        group4(16, 1'b0);
        idle(1'b1);
        chk("full_pop_noovf", int'(ovf_flag), 0);
        for (int k = 0; k < FD; k++) begin
            chk("full_pop_data", int'(bus.out_data), 4);
            idle(1'b1);
        end
        chk("full_pop_empty", int'(bus.out_valid), 0);

        // partial group discarded at reset; gaps do not matter
        step(50, 1'b1, 1'b1, 1'b0);
        step(50, 1'b1, 1'b1, 1'b0);
        do_reset();
        step(16, 1'b1, 1'b1, 1'b0);
        idle(1'b1);
        step(16, 1'b1, 1'b1, 1'b0);
        step(16, 1'b1, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);
        step(16, 1'b1, 1'b1, 1'b0);
        idle(1'b0);
        chk("rst_grp_data", int'(bus.out_data), 4);
        idle(1'b1);
        chk("rst_grp_single", int'(bus.out_valid), 0);

        // random traffic
        for (int n = 0; n < 600; n++) begin
            rnd16 = 16'($urandom);
            if ($urandom_range(0, 3) == 0) d = int'($signed(rnd16));
            else d = int'($urandom_range(0, 600)) - 300;
            step(d, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 19) == 0);
            if (n == 300) do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
